// File: rtl/light_ctrl_pkg.sv
// Shared types for the multi-channel light controller.
// Mode encoding and per-channel light state.
package light_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'b00,
    MODE_MOMENTARY = 2'b01,
    MODE_TIMED     = 2'b10,
    MODE_RSVD      = 2'b11
  } light_mode_t;

  typedef enum logic {
    LIGHT_OFF = 1'b0,
    LIGHT_ON  = 1'b1
  } light_state_t;

endpackage

// File: rtl/light_debounce.sv
// Button conditioning: 2-FF synchroniser, debounce counter,
// and a registered rising-edge pulse of the debounced level.
module light_debounce
  import light_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level_d;
  logic [CW-1:0] cnt;

  // rise is visible the cycle after level changes, so press
  // and any light update driven by rise land on the same edge
  assign rise = level & ~level_d;

  // two-stage synchroniser on the raw pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // count consecutive differing samples; any match restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // delayed level and one-cycle press pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= rise;
    end
  end

endmodule

// File: rtl/multi_light_controller.sv
// Multi-channel light controller: per-channel debounced button
// driving a light in toggle, momentary or timed auto-off mode.
module multi_light_controller
  import light_ctrl_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     button,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic                  all_off,
  output logic [NUM_CH-1:0]     light,
  output logic [NUM_CH-1:0]     press_evt,
  output logic [NUM_CH-1:0]     timeout_evt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          level;
    logic          rise;
    logic          to;
    light_mode_t   mode_in;
    light_mode_t   mode_q;
    light_state_t  st;
    logic [TW-1:0] timer;

    assign mode_in        = light_mode_t'(mode[2*i +: 2]);
    assign light[i]       = (st == LIGHT_ON);
    assign timeout_evt[i] = to;

    light_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .button(button[i]),
      .level (level),
      .press (press_evt[i]),
      .rise  (rise)
    );

    // light state, auto-off timer and mode tracking; all_off
    // and a mode switch both force the channel off first
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st     <= LIGHT_OFF;
        timer  <= '0;
        mode_q <= MODE_TOGGLE;
        to     <= 1'b0;
      end else begin
        to     <= 1'b0;
        mode_q <= mode_in;
        if (all_off || (mode_q != mode_in)) begin
          st    <= LIGHT_OFF;
          timer <= '0;
        end else begin
          unique case (mode_q)
            MODE_TOGGLE: begin
              if (rise)
                st <= (st == LIGHT_ON) ? LIGHT_OFF : LIGHT_ON;
            end
            MODE_MOMENTARY: begin
              st <= level ? LIGHT_ON : LIGHT_OFF;
            end
            MODE_TIMED: begin
              if (rise) begin
                st    <= LIGHT_ON;
                timer <= TW'(TIMEOUT_CYCLES - 1);
              end else if (st == LIGHT_ON) begin
                if (timer == '0) begin
                  st <= LIGHT_OFF;
                  to <= 1'b1;
                end else begin
                  timer <= timer - 1'b1;
                end
              end
            end
            default: begin
              st <= LIGHT_OFF;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/multi_light_controller.md
Name: multi_light_controller

Overview:
Multi-channel, parametrised light controller. Each channel takes a raw, asynchronous push-button and drives one registered light output. Per-channel mode selects toggle, momentary or timed auto-off behaviour. Inputs are synchronised and debounced on-chip; a global all_off clears every channel. Sits between board button pins and lamp/LED drivers.

Parameters:
NUM_CH, 4, number of independent button/light channels (>=1)
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a button level change (>=1)
TIMEOUT_CYCLES, 1000, ON duration in TIMED mode, in clk cycles (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
button  input  NUM_CH  raw asynchronous buttons, 1 = pressed
mode  input  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]
all_off  input  1  synchronous clear of all channels
light  output  NUM_CH  registered light outputs, 1 = on
press_evt  output  NUM_CH  one-cycle pulse per accepted press (debounced rising edge)
timeout_evt  output  NUM_CH  one-cycle pulse when a TIMED channel expires

Behaviour:
- Reset: light, press_evt and timeout_evt = 0. Synchronisers, debounced level, debounce counters and timers = 0. Registered mode copy = 0 (TOGGLE).
- Synchroniser: 2-FF per channel on button.
- Debounce: counter runs while the synchronised value differs from the debounced level; it clears whenever they are equal, so any bounce restarts the count. When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
- press_evt[i] = debounced level 0->1, registered; high exactly one cycle.
- Latency: raw high sampled at edge k with no bounce -> debounced level changes at edge k+1+DEBOUNCE_CYCLES. press_evt and the light change are both at edge k+2+DEBOUNCE_CYCLES.
- Modes, encoded 2-bit:
  - TOGGLE=00: press_evt inverts light.
  - MOMENTARY=01: light follows the debounced level, one register stage, aligned with press_evt on press; it clears on the same latency after release.
  - TIMED=10: press loads the timer with TIMEOUT_CYCLES-1 and sets light=1. Timer decrements each cycle while light=1. On the cycle the timer is 0 and light=1, light<=0 and timeout_evt pulses, so ON lasts exactly TIMEOUT_CYCLES cycles. A press while ON reloads the timer (retrigger); light stays 1 and there is no timeout_evt.
  - RSVD=11: light forced 0; press_evt still generated.
- Per-channel state: OFF/ON. TIMED adds a timer register of width $clog2(TIMEOUT_CYCLES+1); the timer wraps never, it saturates at 0.
- Mode change: the registered mode copy differing from the mode input -> that channel's light<=0 and timer<=0 that cycle; the copy updates. Pending debounce is unaffected.
- all_off=1: all light<=0, timers<=0, no timeout_evt, highest priority over a same-cycle press or expiry. press_evt still reports presses.
- Same-cycle press and expiry in TIMED: the press wins; it reloads, light stays 1 and timeout_evt=0.
- Reset asserted mid-operation: everything returns to reset values immediately. A button held through reset deassertion produces one press after full debounce latency.
- Channels are fully independent apart from all_off.

Decomposition:
- Package light_ctrl_pkg: typedef enum logic [1:0] light_mode_t {MODE_TOGGLE, MODE_MOMENTARY, MODE_TIMED, MODE_RSVD}; typedef enum logic {LIGHT_OFF, LIGHT_ON} light_state_t.
- Sub-module light_debounce (parameter DEBOUNCE_CYCLES) contains the synchroniser, debounce counter and registered rising-edge pulse. Its outputs are the debounced level and press pulse. Instantiate it once per channel in a generate loop.
- Mode/timer logic lives in the top module, also in the per-channel generate.

Test Plan:
- Config for all tests: NUM_CH=2, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=10.
- TOGGLE, clean press: button[0] high from edge 0 for 20 cycles -> press_evt[0] pulse and light[0]=1 at edge 6. A second clean press toggles light[0] back to 0; light[1] stays 0 throughout.
- Bounce: button[0] toggles 1/0 every 2 cycles for 12 cycles, then holds 1 -> no press_evt during bounce; a single press_evt 6 edges after the final rising sample.
- MOMENTARY: mode[1:0]=01, hold button[0] 15 cycles, then release -> light[0]=1 from edge 6; it returns to 0 six edges after the first low sample; press_evt is a single pulse.
- TIMED with expiry and retrigger: mode=10, press -> light[0]=1 for exactly 10 cycles, then timeout_evt[0] pulse. Repeat with a second press landing 5 cycles after turn-on -> total ON = 15 cycles, one timeout_evt.
- Priority: all_off asserted on the same cycle as a press_evt in TOGGLE -> light=0, press_evt=1. Separately, change mode 00->10 while light[0]=1 -> light[0]=0 next edge.
- Reset mid-operation: assert reset while TIMED light[0]=1 and mid-debounce -> all outputs 0 immediately. With button held through deassertion -> one press_evt at the full debounce latency.
